adder_hw4: RTL and testbench
============================

// Module: adder_hw4
// PURPOSE
//   Registered three-adder datapath: adder A = in1+in2, adder B = in3+in4,
//   adder C = A+B. A 2-bit select picks which adder result is loaded into the
//   8-bit output register each clock. Small arithmetic leaf block used as an
//   accumulate/sum stage. All sums are modulo 256.
// PARAMETERS
//   none (all data widths fixed at 8 bits)
// PORTS
//   clk    input   1  system clock; all state updates on rising edge
//   rst    input   1  reset, asynchronous, active-low (0 = reset asserted)
//   enbl   input   2  result select: 0=A, 1=B, 2=C, 3=hold
//   in1    input   8  operand 1, unsigned
//   in2    input   8  operand 2, unsigned
//   in3    input   8  operand 3, unsigned
//   in4    input   8  operand 4, unsigned
//   out    output  8  registered selected sum
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-low on rst.
//   - Reset: rst=0 forces out=8'd0 immediately, without waiting for a clk edge.
//     out stays 0 while rst=0, regardless of clk, enbl or inputs.
//   - Adders, all combinational and 8 bits wide; carry-out is discarded:
//     A = (in1+in2) mod 256; B = (in3+in4) mod 256; C = (A+B) mod 256.
//   - Output register update on each rising clk edge with rst=1:
//     enbl=2'd0 -> out<=A; 2'd1 -> out<=B; 2'd2 -> out<=C; 2'd3 -> out<=out.
//   - Latency: exactly 1 clk edge from inputs/enbl to out. The output is purely
//     registered, with no combinational path from inputs to out.
//   - Overflow: silent wrap. No carry/overflow flag. Example: 200+100 -> 44.
//   - enbl X/Z (undriven): treat as hold; out keeps its value. Hold is also
//     the default branch in the RTL.
//   - Reset deassertion (rst 0->1): the first load occurs at the first rising
//     edge after deassertion. Until that edge, out stays 0.
//   - Reset mid-operation: out clears to 0 at once, overriding any in-flight
//     select.
//   - Inputs may change every cycle. Only the values present at the edge
//     matter.
// TESTING
//   1. rst=0, random inputs and enbl, toggle clk -> out==0 throughout.
//      Drop rst to 0 between edges -> out==0 with no edge.
//   2. rst=1, in1=2, in2=3, in3=4, in4=5, enbl=0 -> out==5 after next edge.
//   3. Same operands, enbl=1 -> out==9 after next edge.
//      Then enbl=2 -> out==14 after next edge and stable on later edges.
//   4. From out==14, set enbl=3 and change in1..in4 to 10,20,30,40
//      -> out stays 14 over 3 edges.
//   5. Wrap: in1=200, in2=100, in3=255, in4=1. enbl=0 -> 44, enbl=1 -> 0,
//      enbl=2 -> 44.
//   6. Latency check: change enbl between edges -> out changes only at the
//      next rising edge. Random 1000-cycle compare against a reference model.

Source files
------------

// File: rtl/adder_hw4.sv
// Registered three-adder datapath: A=in1+in2, B=in3+in4, C=A+B (all mod 256).
// enbl picks which sum loads into the output register; 3 (or any unknown) holds.
module adder_hw4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] enbl,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  output logic [7:0] out
);

  logic [7:0] sum_a;
  logic [7:0] sum_b;
  logic [7:0] sum_c;
  logic [7:0] out_q;
  logic [7:0] out_d;

  // Carry-out is dropped on purpose: every sum wraps silently at 8 bits.
  assign sum_a = in1 + in2;
  assign sum_b = in3 + in4;
  assign sum_c = sum_a + sum_b;

  always_comb begin
    out_d = out_q;
    case (enbl)
      2'd0:    out_d = sum_a;
      2'd1:    out_d = sum_b;
      2'd2:    out_d = sum_c;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_q <= 8'd0;
    else      out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_adder_hw4.sv
// Scoreboard bench for adder_hw4: the driver queues the expected output for each
// edge, and a monitor compares it just after that edge.
module tb_adder_hw4;

  logic       clk;
  logic       rst;
  logic [1:0] enbl;
  logic [7:0] in1, in2, in3, in4;
  logic [7:0] out;

  int checks = 0;
  int passes = 0;
  logic [7:0] sb_q[$];
  logic [7:0] model_q;
  bit         done = 0;

  adder_hw4 dut (
    .clk  (clk),
    .rst  (rst),
    .enbl (enbl),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .in4  (in4),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: one queued expectation is consumed per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) chk("sb_out", out, sb_q.pop_front());
    end
  end

  // Drive one cycle between edges; out must not move before the next edge.
  task automatic drive(input logic r, input logic [1:0] e,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       input logic [7:0] exp);
    @(negedge clk);
    rst = r; enbl = e; in1 = a; in2 = b; in3 = c; in4 = d;
    if (!r) model_q = 8'd0;
    #1;
    chk("pre_edge", out, model_q);
    model_q = exp;
    sb_q.push_back(exp);
  endtask

  initial begin
    logic [1:0] e;
    logic [7:0] a, b, c, d, sa, sbv, exp;
    logic       r;

    rst = 1'b0; enbl = 2'd0; in1 = 8'd0; in2 = 8'd0; in3 = 8'd0; in4 = 8'd0;
    model_q = 8'd0;
    #2;
    chk("reset_init", out, 8'd0);

    // 1. Held in reset with random traffic.
    for (int i = 0; i < 5; i++)
      drive(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'd0);

    // 2-3. Basic selects on 2,3,4,5.
    drive(1'b1, 2'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5);
    drive(1'b1, 2'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd9);
    drive(1'b1, 2'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd14);
    drive(1'b1, 2'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd14);

    // 4. Hold while operands change.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 2'd3, 8'd10, 8'd20, 8'd30, 8'd40, 8'd14);

    // 5. Wraparound.
    drive(1'b1, 2'd0, 8'd200, 8'd100, 8'd255, 8'd1, 8'd44);
    drive(1'b1, 2'd1, 8'd200, 8'd100, 8'd255, 8'd1, 8'd0);
    drive(1'b1, 2'd2, 8'd200, 8'd100, 8'd255, 8'd1, 8'd44);
    drive(1'b1, 2'd0, 8'd255, 8'd255, 8'd128, 8'd128, 8'd254);
    drive(1'b1, 2'd2, 8'd255, 8'd255, 8'd128, 8'd128, 8'd254);

    // Asynchronous reset between edges, no clock edge needed.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset", out, 8'd0);
    model_q = 8'd0;
    drive(1'b1, 2'd1, 8'd0, 8'd0, 8'd7, 8'd8, 8'd15);

    // 6. Random compare against the reference sums.
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 39) != 0);
      e = 2'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      sa = a + b;
      sbv = c + d;
      if (!r)            exp = 8'd0;
      else if (e == 2'd0) exp = sa;
      else if (e == 2'd1) exp = sbv;
      else if (e == 2'd2) exp = sa + sbv;
      else               exp = model_q;
      drive(r, e, a, b, c, d, exp);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());

    done = 1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
